reg_bus_arbiter: RTL and testbench



---
 rtl/reg_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin owner of the internal register bus.
// N requesters share one 16-bit address / 32-bit data bus. Each grant runs
// a fixed DRIVE -> SAMPLE -> ACK sequence, so a transaction occupies the bus
// for 4 cycles including the arbitration cycle in IDLE.
// Optional build macro REG_ARB_LOCK_EN adds req_lock[N] and a LOCKED state
// that keeps the bus with the current owner for atomic read-modify-write.
module reg_bus_arbiter #(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      req_valid,
    input  logic [N-1:0]      req_wr,
    input  logic [16*N-1:0]   req_addr,
    input  logic [32*N-1:0]   req_wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [N-1:0]      req_lock,
`endif
    output logic [N-1:0]      req_ack,
    output logic [31:0]       req_rdata,
    output logic [N-1:0]      grant,
    output logic              busy,
    output logic [15:0]       reg_addr,
    inout  wire  [31:0]       reg_data,
    output logic              reg_wr
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        ACK
`ifdef REG_ARB_LOCK_EN
        , LOCKED
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [IW-1:0]   r_owner;     // requester currently holding the bus
    logic [IW-1:0]   r_last;      // round-robin pointer: last winner from IDLE
    logic            r_wr;
    logic [15:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;

    logic            w_rr_found;
    logic [IW-1:0]   w_rr_winner;
    int              w_scan_sum;
    logic [IW-1:0]   w_scan_idx;
    logic            w_load;
    logic [IW-1:0]   w_load_idx;
    logic            w_drive;
    logic [N-1:0]    w_owner_onehot;

    // One-hot decode of the current owner index
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign w_owner_onehot[gi] = (r_owner == IW'(gi));
        end
    endgenerate

    // Round-robin scan: last+1, last+2, ... (mod N); nearest valid wins.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_scan_sum  = 0;
        w_scan_idx  = '0;
        for (int k = N; k >= 1; k--) begin
            w_scan_sum = int'(r_last) + k;
            if (w_scan_sum >= N) begin
                w_scan_sum = w_scan_sum - N;
            end
            w_scan_idx = IW'(w_scan_sum);
            if (req_valid[w_scan_idx]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_scan_idx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and request-latch enable
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_idx   = w_rr_winner;
        case (r_state)
            IDLE: begin
                if (w_rr_found) begin
                    w_state_next = DRIVE;
                    w_load       = 1'b1;
                end
            end
            DRIVE:  w_state_next = SAMPLE;
            SAMPLE: w_state_next = ACK;
            ACK: begin
`ifdef REG_ARB_LOCK_EN
                if (req_lock[r_owner]) begin
                    w_state_next = LOCKED;
                end else begin
                    w_state_next = IDLE;
                end
`else
                w_state_next = IDLE;
`endif
            end
`ifdef REG_ARB_LOCK_EN
            LOCKED: begin
                // Only the owner may continue; others wait, pointer untouched
                if (req_valid[r_owner]) begin
                    w_state_next = DRIVE;
                    w_load       = 1'b1;
                    w_load_idx   = r_owner;
                end else if (!req_lock[r_owner]) begin
                    w_state_next = IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the winner's request fields; capture bus data leaving SAMPLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= '0;
            r_last  <= IW'(N - 1);
            r_wr    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
        end else begin
            if (w_load) begin
                r_owner <= w_load_idx;
                r_wr    <= req_wr[w_load_idx];
                r_addr  <= req_addr[16*int'(w_load_idx) +: 16];
                r_wdata <= req_wdata[32*int'(w_load_idx) +: 32];
                if (r_state == IDLE) begin
                    r_last <= w_load_idx;
                end
            end
            if (r_state == SAMPLE) begin
                r_rdata <= reg_data;
            end
        end
    end

    // Bus and requester-side outputs decoded from the registered state
    always_comb begin
        busy     = (r_state != IDLE);
        grant    = busy ? w_owner_onehot : '0;
        req_ack  = (r_state == ACK) ? w_owner_onehot : '0;
        reg_addr = 16'h0000;
        if (r_state == DRIVE || r_state == SAMPLE || r_state == ACK) begin
            reg_addr = r_addr;
        end
        w_drive  = (r_state == DRIVE) && r_wr;
        reg_wr   = w_drive;
    end

    assign req_rdata = r_rdata;
    assign reg_data  = w_drive ? r_wdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter (N = 3): directed bus cases plus random
// traffic, checked by a scoreboard fed from a transaction-level model.
module tb_reg_bus_arbiter;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_wr;
    logic [16*N-1:0]   req_addr;
    logic [32*N-1:0]   req_wdata;
`ifdef REG_ARB_LOCK_EN
    logic [N-1:0]      req_lock = '0;
`endif
    logic [N-1:0]      req_ack;
    logic [31:0]       req_rdata;
    logic [N-1:0]      grant;
    logic              busy;
    logic [15:0]       reg_addr;
    wire  [31:0]       reg_data;
    logic              reg_wr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pol [N];          // 0 = hold until ack, 1 = random, 2 = streaming

    typedef struct {
        int          who;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          t0;
    } txn_t;

    txn_t        sb_q [$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] slv_mem [0:255];
    int          m_last = N - 1;
    int          m_free = 0;
    bit          ref_init = 1'b0;
    bit          slv_init = 1'b0;

    reg_bus_arbiter #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef REG_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .grant     (grant),
        .busy      (busy),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .reg_wr    (reg_wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 16'h10) return 32'hDEAD_BEEF;
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Register slave: answers reads whenever the bus is owned and not writing
    assign reg_data = (busy && !reg_wr) ? slv_mem[reg_addr[7:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!slv_init) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= init_val(i);
            slv_init <= 1'b1;
        end else if (reg_wr) begin
            slv_mem[reg_addr[7:0]] <= reg_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: whenever the bus is free, the first valid requester
    // after the previous winner (cyclically) gets the bus for 4 cycles.
    always @(negedge clk) begin
        int   w;
        int   idx;
        txn_t t;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (!reset_n) begin
            sb_q.delete();
            m_last = N - 1;
            m_free = 0;
        end else if (cyc >= m_free && req_valid != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            t.who   = w;
            t.wr    = req_wr[w];
            t.addr  = req_addr[16*w +: 16];
            t.wdata = req_wdata[32*w +: 32];
            if (t.wr) ref_mem[t.addr[7:0]] = t.wdata;
            t.rdata = ref_mem[t.addr[7:0]];
            t.t0    = cyc;
            sb_q.push_back(t);
            m_last  = w;
            m_free  = cyc + 4;
        end
    end

    // Monitor: compares the visible bus/requester outputs with the scoreboard
    always @(negedge clk) begin
        int   ph;
        txn_t t;
        if (!reset_n) begin
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_ack", 32'(req_ack), 32'h0);
            chk("rst_reg_wr", 32'(reg_wr), 32'h0);
            chk("rst_reg_addr", 32'(reg_addr), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_rdata", req_rdata, 32'h0);
        end else begin
            ph = (sb_q.size() > 0) ? cyc - sb_q[0].t0 : 0;
            if (ph <= 0) begin
                chk("idle_grant", 32'(grant), 32'h0);
                chk("idle_ack", 32'(req_ack), 32'h0);
                chk("idle_reg_wr", 32'(reg_wr), 32'h0);
                chk("idle_reg_addr", 32'(reg_addr), 32'h0);
                chk("idle_busy", 32'(busy), 32'h0);
            end else begin
                t = sb_q[0];
                chk("grant", 32'(grant), 32'(1) << t.who);
                chk("busy", 32'(busy), 32'h1);
                chk("reg_addr", 32'(reg_addr), 32'(t.addr));
                if (ph == 1) begin
                    chk("drive_reg_wr", 32'(reg_wr), 32'(t.wr));
                    if (t.wr) chk("drive_reg_data", reg_data, t.wdata);
                end else begin
                    chk("reg_wr_low", 32'(reg_wr), 32'h0);
                end
                if (ph >= 3) begin
                    chk("ack", 32'(req_ack), 32'(1) << t.who);
                    chk("rdata", req_rdata, t.rdata);
                    $display("txn cyc=%0d req%0d wr=%0d addr=%h wdata=%h rdata=%h",
                             cyc, t.who, t.wr, t.addr, t.wdata, req_rdata);
                    void'(sb_q.pop_front());
                end else begin
                    chk("ack_early", 32'(req_ack), 32'h0);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [15:0] a, input logic [31:0] d);
        req_valid[i]         = 1'b1;
        req_wr[i]            = wr;
        req_addr[16*i +: 16] = a;
        req_wdata[32*i +: 32] = d;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
    endtask

    // One clock: sample ack, then update requesters just after the edge
    task automatic tick();
        logic [N-1:0] ack;
        @(negedge clk);
        ack = req_ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                if (pol[i] == 2) rand_req(i);
                else req_valid[i] = 1'b0;
            end else if (pol[i] == 1 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
                rand_req(i);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || req_valid != '0 || busy) && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(n < 60), 32'h1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) pol[i] = 0;
        req_valid = '0;
        reset_n   = 1'b0;
        repeat (3) tick();
        reset_n   = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) pol[i] = 0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        reset_n   = 1'b1;
        #1;
        reset_n   = 1'b0;
        repeat (3) tick();
        reset_n   = 1'b1;

        // Read from requester 0, slave returns DEADBEEF at 0x0010
        set_req(0, 1'b0, 16'h0010, 32'h0);
        wait_idle("drain_read");
        chk("read_rdata", req_rdata, 32'hDEAD_BEEF);

        // Write from requester 1, then read it back from requester 2
        set_req(1, 1'b1, 16'h0004, 32'h1234_5678);
        wait_idle("drain_write");
        chk("write_readback", req_rdata, 32'h1234_5678);
        set_req(2, 1'b0, 16'h0004, 32'h0);
        wait_idle("drain_rdback");
        chk("read_after_write", req_rdata, 32'h1234_5678);

        // Fairness: everyone streaming from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            pol[i] = 2;
            rand_req(i);
        end
        repeat (40) tick();
        for (int i = 0; i < N; i++) pol[i] = 0;
        wait_idle("drain_fair");

        // Early drop: valid for one cycle still completes one transaction
        set_req(0, 1'b0, 16'h0033, 32'h0);
        tick();
        req_valid[0] = 1'b0;
        wait_idle("drain_early");

        // Reset during SAMPLE of a requester-0 read, requester 1 waiting
        do_reset();
        set_req(0, 1'b0, 16'h0010, 32'h0);
        set_req(1, 1'b0, 16'h0044, 32'h0);
        tick();
        tick();
        chk("pre_abort_busy", 32'(busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_grant", 32'(grant), 32'h0);
        chk("abort_ack", 32'(req_ack), 32'h0);
        chk("abort_reg_wr", 32'(reg_wr), 32'h0);
        chk("abort_reg_addr", 32'(reg_addr), 32'h0);
        req_valid[0] = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_idle("drain_abort");
        chk("abort_next_rdata", req_rdata, init_val(16'h44));

        // Random traffic
        for (int i = 0; i < N; i++) pol[i] = 1;
        repeat (300) tick();
        for (int i = 0; i < N; i++) pol[i] = 0;
        wait_idle("drain_random");
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
